// File: rtl/msrv32_pkg.sv
// Shared msrv32 encodings: PC source selects, fetch-state and pending-redirect types.
package msrv32_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'b00,
    PEND_EPC  = 2'b01,
    PEND_TRAP = 2'b10
  } pend_e;

endpackage

// File: rtl/msrv32_fetch_ctrl.sv
// Fetch sequencer: selects the PC source, gates PC loads across AHB wait states,
// and queues trap/mret redirects that arrive while the instruction port is stalled.
module msrv32_fetch_ctrl (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       trap_taken_in,
  input  logic       mret_in,
  input  logic       branch_taken_in,
  input  logic       misaligned_instr_in,
  input  logic       ahb_ready_in,
  output logic [1:0] pc_src_out,
  output logic       pc_en_out,
  output logic       i_valid_out,
  output logic       flush_out,
  output logic       misaligned_trap_out,
  output logic       stall_out
);
  import msrv32_pkg::*;

  fetch_state_e state_q, state_d;
  pend_e        pend_q,  pend_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_BOOT;
      pend_q  <= PEND_NONE;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_STALL: begin
        if (ahb_ready_in) begin
          // Any queued redirect is consumed on the first ready cycle.
          state_d = ST_RUN;
          pend_d  = PEND_NONE;
        end else begin
          state_d = ST_STALL;
          if (trap_taken_in)
            pend_d = PEND_TRAP;
          else if (mret_in && (pend_q == PEND_NONE))
            pend_d = PEND_EPC;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_src_out          = PC_SRC_NEXT;
    pc_en_out           = 1'b0;
    i_valid_out         = 1'b0;
    flush_out           = 1'b0;
    misaligned_trap_out = 1'b0;
    stall_out           = 1'b0;
    if (rst_in) begin
      pc_src_out = PC_SRC_BOOT;
      flush_out  = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_src_out = PC_SRC_BOOT;
          pc_en_out  = 1'b1;
          flush_out  = 1'b1;
        end
        ST_RUN, ST_STALL: begin
          i_valid_out = 1'b1;
          if (!ahb_ready_in) begin
            stall_out = 1'b1;
          end else begin
            pc_en_out = 1'b1;
            if ((pend_q == PEND_TRAP) || trap_taken_in) begin
              pc_src_out = PC_SRC_TRAP;
              flush_out  = 1'b1;
            end else if ((pend_q == PEND_EPC) || mret_in) begin
              pc_src_out = PC_SRC_EPC;
              flush_out  = 1'b1;
            end else if (branch_taken_in && misaligned_instr_in) begin
              // PC holds; the CSR unit answers with trap_taken_in.
              pc_en_out           = 1'b0;
              misaligned_trap_out = 1'b1;
              flush_out           = 1'b1;
            end else if (branch_taken_in) begin
              flush_out = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
